// File: rtl/mult_issue_ctrl_pkg.sv
// Shared definitions for the multiply issue controller: state encoding
// and the width of the wait-cycle down-counter.
package mult_issue_ctrl_pkg;

    localparam int MIC_CNT_W = 4;

    typedef enum logic [1:0] {
        MIC_IDLE  = 2'b00,
        MIC_BUSY  = 2'b01,
        MIC_WRITE = 2'b10
    } mic_state_t;

endpackage

// File: rtl/mult_issue_ctrl.sv
// Multi-cycle issue controller for the 8-bit multiply path.
// Latches operands on a MULT, holds them steady for WAIT_CYCLES cycles
// while the external combinational multiplier settles, then issues a
// one-cycle write-back pulse carrying the low byte of the product.
module mult_issue_ctrl
    import mult_issue_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
)
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] X_IN,
    input  logic [7:0] Y_IN,
    input  logic [2:0] DEST_IN,
    output logic [7:0] MX,
    output logic [7:0] MY,
    input  logic [7:0] MRESULT,
    output logic [7:0] WB_DATA,
    output logic [2:0] WB_ADDR,
    output logic       WB_EN,
    output logic       STALL,
    output logic       BUSY
);

    // Counter cannot represent a wait outside 1..15, so refuse to elaborate.
    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : gen_bad_wait_cycles
            $fatal(1, "mult_issue_ctrl: WAIT_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [MIC_CNT_W-1:0] CNT_LOAD = MIC_CNT_W'(WAIT_CYCLES);
    localparam logic [MIC_CNT_W-1:0] CNT_ONE  = MIC_CNT_W'(1);

    mic_state_t           state;
    mic_state_t           stateNext;
    logic [MIC_CNT_W-1:0] cnt;
    logic [MIC_CNT_W-1:0] cntNext;
    logic [7:0]           mxNext;
    logic [7:0]           myNext;
    logic [7:0]           wbDataNext;
    logic [2:0]           wbAddrNext;

    // Next-state and datapath load decisions; everything holds by default
    // so operands only ever change on the accept edge.
    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        mxNext     = MX;
        myNext     = MY;
        wbDataNext = WB_DATA;
        wbAddrNext = WB_ADDR;
        case (state)
            MIC_IDLE: begin
                if (START) begin
                    mxNext     = X_IN;
                    myNext     = Y_IN;
                    wbAddrNext = DEST_IN;
                    cntNext    = CNT_LOAD;
                    stateNext  = MIC_BUSY;
                end
            end
            MIC_BUSY: begin
                if (cnt > CNT_ONE) begin
                    cntNext = cnt - CNT_ONE;
                end else begin
                    wbDataNext = MRESULT;
                    stateNext  = MIC_WRITE;
                end
            end
            MIC_WRITE: begin
                stateNext = MIC_IDLE;
            end
            default: begin
                stateNext = MIC_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and drops any
    // write-back that was about to be issued.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= MIC_IDLE;
            cnt     <= '0;
            MX      <= '0;
            MY      <= '0;
            WB_DATA <= '0;
            WB_ADDR <= '0;
            WB_EN   <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            MX      <= mxNext;
            MY      <= myNext;
            WB_DATA <= wbDataNext;
            WB_ADDR <= wbAddrNext;
            WB_EN   <= (stateNext == MIC_WRITE);
        end
    end

    // PC hold: asserted while a MULT is being accepted or waited on, released
    // in WRITE so the PC advances on the same edge the register file writes.
    always_comb begin
        BUSY  = (state != MIC_IDLE);
        STALL = !RESET && (((state == MIC_IDLE) && START) || (state == MIC_BUSY));
    end

endmodule

// File: doc/mult_issue_ctrl.md
# mult_issue_ctrl

Multi-cycle issue controller for the 8-bit multiply path. It sits between the instruction decoder / register-file read ports and `multUnit`. On a MULT instruction it latches the operands and drives them steadily into the multiplier. It holds the PC via `STALL` while the combinational product settles, then issues a single write-back pulse of the 8-bit product to the register file.

## Interface
- `WAIT_CYCLES`, default 1: number of BUSY cycles operands are held before the product is captured. Legal range is 1..15.
- `CLK` input, 1 bit: processor clock; all state updates on the rising edge.
- `RESET` input, 1 bit: synchronous, active-high reset.
- `START` input, 1 bit: decoder asserts it for a MULT instruction; held high while the instruction is stalled.
- `X_IN` input, 8 bits: operand 1 from register-file read port 1.
- `Y_IN` input, 8 bits: operand 2 from register-file read port 2.
- `DEST_IN` input, 3 bits: destination register address.
- `MX` output, 8 bits: registered operand to `multUnit.X`.
- `MY` output, 8 bits: registered operand to `multUnit.Y`.
- `MRESULT` input, 8 bits: `multUnit.RESULT`.
- `WB_DATA` output, 8 bits: registered product to register-file write data.
- `WB_ADDR` output, 3 bits: registered destination address.
- `WB_EN` output, 1 bit: register-file write enable, one-cycle pulse.
- `STALL` output, 1 bit: PC hold, combinational.
- `BUSY` output, 1 bit: high whenever state is not IDLE.

## Operation
- FSM states:
  - IDLE
  - BUSY: 4-bit down-counter `cnt`
  - WRITE
- IDLE with `START`=1:
  - latch `MX`<=`X_IN`, `MY`<=`Y_IN`, `WB_ADDR`<=`DEST_IN`
  - `cnt`<=`WAIT_CYCLES`
  - go to BUSY
- IDLE with `START`=0: hold; all registers keep their values.
- BUSY with `cnt`>1: `cnt`<=`cnt`-1; `MX`/`MY` stay unchanged, so operands are stable for the whole wait.
- BUSY with `cnt`==1: `WB_DATA`<=`MRESULT`; go to WRITE.
- WRITE: `WB_EN`=1 for exactly this cycle; next state is IDLE unconditionally.
- `START` is ignored in BUSY and WRITE.
  - The same instruction is still presented during WRITE and must not retrigger.
  - `START` sampled in IDLE on the cycle after WRITE begins a new multiply.
- `STALL` = (state==IDLE & `START`) | (state==BUSY). It is low in WRITE, so the PC advances on the same edge the register file writes.
- Arithmetic: no width change. `WB_DATA` is the 8-bit `MRESULT` taken verbatim; the product high byte is discarded.
- `WAIT_CYCLES` outside 1..15 is a configuration error. An elaboration-time check stops simulation.

## Timing
- Reset values: state=IDLE, `cnt`=0, `MX`=`MY`=`WB_DATA`=0, `WB_ADDR`=0, `WB_EN`=0, `BUSY`=0.
- `STALL` is forced 0 while `RESET`=1.
- `RESET` mid-operation (BUSY or WRITE): on that edge go to IDLE and clear all registers. No write-back occurs; any pending `WB_EN` is suppressed.
- Latency from the `START` edge to the `WB_EN`-high cycle is `WAIT_CYCLES`+1 cycles. A MULT occupies `WAIT_CYCLES`+2 cycles in total (IDLE-accept, BUSY×`WAIT_CYCLES`, WRITE).
- `MX`/`MY` change only on the accept edge. `multUnit` (3 time-unit delay) must settle within `WAIT_CYCLES` clock periods; with the 8-unit clock, `WAIT_CYCLES`=1 suffices.
- `WB_EN` is a registered state decode. `WB_DATA` and `WB_ADDR` are stable for the whole WRITE cycle.

## Structure
- Shared package holds:
  - state encoding constants `MIC_IDLE`=2'b00, `MIC_BUSY`=2'b01, `MIC_WRITE`=2'b10
  - counter width constant `MIC_CNT_W`=4
- Single module, no sub-modules. `multUnit` is instantiated by the datapath top, not inside this block; the testbench instantiates both.

## Test plan
- Reset then idle: `RESET`=1 for 2 cycles, `START`=0 -> all outputs 0, `STALL`=0, `BUSY`=0.
- Basic multiply, `WAIT_CYCLES`=1: `X_IN`=5, `Y_IN`=5, `DEST_IN`=3, `START` held -> `STALL` high for 2 cycles; in the WRITE cycle `WB_EN`=1, `WB_DATA`=25, `WB_ADDR`=3; then IDLE.
- Truncation and no retrigger: `X_IN`=`Y_IN`=8'hFF, `START` held through WRITE -> `WB_DATA`=8'h01, exactly one `WB_EN` pulse.
- Long wait, `WAIT_CYCLES`=4: `X_IN`=15, `Y_IN`=3, with `X_IN` changed to 0 during BUSY -> `MX` stays 15, `STALL` high 5 cycles, `WB_DATA`=45.
- Reset mid-BUSY, `WAIT_CYCLES`=3: assert `RESET` on the 2nd BUSY cycle -> next cycle state IDLE, outputs 0, no `WB_EN` ever.
- Back-to-back: second `START` (7×6, dest 1) sampled the cycle after WRITE -> second `WB_EN` with `WB_DATA`=42, `WB_ADDR`=1, and no dead cycle beyond IDLE-accept.
